phase_sequencer: RTL

//  Multi-cycle phase controller for the CPU core: steps the datapath through IF/ID/EX/MEM/WB,

---
 rtl/phase_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB phase controller for the CPU core.
// Strobes are decoded from registered state, wait counter and the controls latched in ID/EX.
module phase_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step_mode,
    input  logic             ctl_regwrite,
    input  logic             ctl_memwrite,
    input  logic             ctl_memtoreg,
    input  logic             ctl_in,
    input  logic             ctl_out,
    input  logic             ctl_halt,
    input  logic             ctl_jump,
    input  logic             br_taken,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel_br,
    output logic             reg_we,
    output logic             mem_we,
    output logic             in_ack,
    output logic             out_valid,
    output logic             halted,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] retired
);

    // state  | meaning
    // IDLE   | stopped at an instruction boundary, waiting for run
    // IF     | instruction fetch, MEM_LAT cycles, IR loaded in the last one
    // ID     | decode, decoder controls captured at the end of the cycle
    // EX     | execute, branch condition captured at the end of the cycle
    // MEM    | data memory access, MEM_LAT cycles, store strobe in the last one
    // WB     | write back, PC update, instruction retires
    // IOWAIT | IN/OUT handshake stall
    // HALT   | stopped by HLT, left only through reset
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF     = 3'd1,
        S_ID     = 3'd2,
        S_EX     = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_IOWAIT = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             lat_regwrite_q, lat_regwrite_d;
    logic             lat_memwrite_q, lat_memwrite_d;
    logic             lat_memtoreg_q, lat_memtoreg_d;
    logic             lat_in_q, lat_in_d;
    logic             lat_out_q, lat_out_d;
    logic             lat_jump_q, lat_jump_d;
    logic             lat_br_q, lat_br_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        retired_d      = retired_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memwrite_d = lat_memwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_in_d       = lat_in_q;
        lat_out_d      = lat_out_q;
        lat_jump_d     = lat_jump_q;
        lat_br_d       = lat_br_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) state_d = S_IF;
            end
            S_IF: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_ID;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ID: begin
                lat_regwrite_d = ctl_regwrite;
                lat_memwrite_d = ctl_memwrite;
                lat_memtoreg_d = ctl_memtoreg;
                lat_in_d       = ctl_in;
                lat_out_d      = ctl_out;
                lat_jump_d     = ctl_jump;
                state_d        = ctl_halt ? S_HALT : S_EX;
            end
            S_EX: begin
                lat_br_d = br_taken;
                cnt_d    = '0;
                if (lat_in_q || lat_out_q)
                    state_d = S_IOWAIT;
                else if (lat_memwrite_q || lat_memtoreg_q)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IOWAIT: begin
                // OUT wins when the decoder flagged both directions
                if (lat_out_q) begin
                    if (out_ready) state_d = S_WB;
                end else if (in_valid) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                cnt_d = '0;
                if (retired_q != RET_MAX) retired_d = retired_q + CNT_W'(1);
                state_d = (run && !step_mode) ? S_IF : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            retired_q      <= '0;
            lat_regwrite_q <= 1'b0;
            lat_memwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_in_q       <= 1'b0;
            lat_out_q      <= 1'b0;
            lat_jump_q     <= 1'b0;
            lat_br_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retired_q      <= retired_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memwrite_q <= lat_memwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_in_q       <= lat_in_d;
            lat_out_q      <= lat_out_d;
            lat_jump_q     <= lat_jump_d;
            lat_br_q       <= lat_br_d;
        end
    end

    // Pure state decodes: reset forces IDLE, so every strobe drops the moment rst_n falls
    assign ir_we     = (state_q == S_IF) && cnt_last;
    assign mem_we    = (state_q == S_MEM) && cnt_last && lat_memwrite_q;
    assign pc_we     = (state_q == S_WB);
    assign reg_we    = (state_q == S_WB) && lat_regwrite_q;
    assign pc_sel_br = (state_q == S_WB) && (lat_jump_q || lat_br_q);
    assign out_valid = (state_q == S_IOWAIT) && lat_out_q;
    assign in_ack    = (state_q == S_IOWAIT) && !lat_out_q && lat_in_q && in_valid;
    assign halted    = (state_q == S_HALT);
    assign phase     = state_q;
    assign retired   = retired_q;

endmodule
